vc_controller: RTL and testbench

//  Control FSM for the 4-way fully-associative victim cache between L1 and physical memory (L2).

---
 rtl/vc_controller.sv | 155 +++++++++++++++
 tb/tb_vc_controller.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_controller.sv
`timescale 1ns/1ps
// Control FSM for a 4-way fully-associative victim cache: keeps tag/valid/dirty per way,
// steers the line-data datapath and LRU regfile, and writes dirty victims back to pmem.
//
// Handshakes: l1_read/l1_write are levels held by L1 until the single-cycle l1_resp pulse;
// pmem_read/pmem_write are levels held constant by this block until pmem_resp is seen.
module vc_controller #(
  parameter int TAG_W    = 11,
  parameter int OFFSET_W = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      l1_read,
  input  logic                      l1_write,
  input  logic [TAG_W-1:0]          l1_tag,
  input  logic                      l1_dirty,
  output logic                      l1_resp,
  output logic                      l1_rdata_sel,
  output logic [1:0]                data_sel,
  output logic [3:0]                data_load,
  output logic                      pmem_read,
  output logic                      pmem_write,
  output logic [TAG_W+OFFSET_W-1:0] pmem_addr,
  input  logic                      pmem_resp,
  output logic                      lru_write,
  output logic [1:0]                lru_way,
  input  logic [1:0]                lru_replace,
  output logic [2:0]                dbg_state,
  output logic [3:0]                dbg_valid
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_MISS = 3'd1;
  localparam logic [2:0] WB      = 3'd2;
  localparam logic [2:0] INSTALL = 3'd3;
  localparam logic [2:0] RD_HIT  = 3'd4;

  logic [2:0]       state;
  logic [1:0]       way;
  logic             way_hit;
  logic [TAG_W-1:0] req_tag;
  logic [TAG_W-1:0] tags [4];
  logic [3:0]       valid;
  logic [3:0]       dirty;

  logic [3:0] hit;
  logic       any_hit;
  logic       any_free;
  logic [1:0] hit_way;
  logic [1:0] free_way;
  logic [1:0] victim;

  // Tags are unique, so at most one hit; both encoders pick the lowest matching way.
  always_comb begin
    hit_way  = 2'd0;
    free_way = 2'd0;
    for (int i = 0; i < 4; i++) begin
      hit[i] = valid[i] && (tags[i] == l1_tag);
    end
    for (int i = 3; i >= 0; i--) begin
      if (hit[i])    hit_way  = 2'(i);
      if (!valid[i]) free_way = 2'(i);
    end
    any_hit  = |hit;
    any_free = ~&valid;
    victim   = any_hit ? hit_way : (any_free ? free_way : lru_replace);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      way     <= 2'd0;
      way_hit <= 1'b0;
      req_tag <= '0;
      valid   <= 4'd0;
      dirty   <= 4'd0;
      for (int i = 0; i < 4; i++) tags[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (l1_write) begin
            way     <= victim;
            way_hit <= any_hit;
            req_tag <= l1_tag;
            state   <= (!any_hit && valid[victim] && dirty[victim]) ? WB : INSTALL;
          end else if (l1_read) begin
            way     <= hit_way;
            req_tag <= l1_tag;
            state   <= any_hit ? RD_HIT : RD_MISS;
          end
        end
        RD_MISS: if (pmem_resp) state <= IDLE;
        WB: begin
          if (pmem_resp) begin
            dirty[way] <= 1'b0;
            state      <= INSTALL;
          end
        end
        INSTALL: begin
          tags[way]  <= req_tag;
          valid[way] <= 1'b1;
          dirty[way] <= way_hit ? (dirty[way] | l1_dirty) : l1_dirty;
          state      <= IDLE;
        end
        RD_HIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    l1_resp      = 1'b0;
    l1_rdata_sel = 1'b0;
    data_sel     = 2'd0;
    data_load    = 4'd0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_addr    = '0;
    lru_write    = 1'b0;
    lru_way      = 2'd0;
    case (state)
      RD_MISS: begin
        pmem_read = 1'b1;
        pmem_addr = {req_tag, {OFFSET_W{1'b0}}};
        if (pmem_resp) begin
          l1_resp      = 1'b1;
          l1_rdata_sel = 1'b1;
        end
      end
      WB: begin
        pmem_write = 1'b1;
        data_sel   = way;
        pmem_addr  = {tags[way], {OFFSET_W{1'b0}}};
      end
      INSTALL: begin
        data_load = 4'b0001 << way;
        data_sel  = way;
        l1_resp   = 1'b1;
        lru_write = 1'b1;
        lru_way   = way;
      end
      RD_HIT: begin
        data_sel  = way;
        l1_resp   = 1'b1;
        lru_write = 1'b1;
        lru_way   = way;
      end
      default: ;
    endcase
  end

  assign dbg_state = state;
  assign dbg_valid = valid;

endmodule

// File: tb/tb_vc_controller.sv
`timescale 1ns/1ps
// Bench for vc_controller: a small cache model predicts every l1_resp, and a negedge
// monitor pops the expected queue whenever the controller completes a request.
module tb_vc_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        l1_read = 1'b0, l1_write = 1'b0, l1_dirty = 1'b0;
  logic [10:0] l1_tag = '0;
  logic        l1_resp, l1_rdata_sel;
  logic [1:0]  data_sel;
  logic [3:0]  data_load;
  logic        pmem_read, pmem_write;
  logic [15:0] pmem_addr;
  logic        pmem_resp = 1'b0;
  logic        lru_write;
  logic [1:0]  lru_way;
  logic [1:0]  lru_replace = 2'd0;
  logic [2:0]  dbg_state;
  logic [3:0]  dbg_valid;

  vc_controller dut (
    .clk(clk), .reset(reset), .l1_read(l1_read), .l1_write(l1_write), .l1_tag(l1_tag),
    .l1_dirty(l1_dirty), .l1_resp(l1_resp), .l1_rdata_sel(l1_rdata_sel), .data_sel(data_sel),
    .data_load(data_load), .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_resp(pmem_resp), .lru_write(lru_write), .lru_way(lru_way), .lru_replace(lru_replace),
    .dbg_state(dbg_state), .dbg_valid(dbg_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Entry layout: [9] rdata_sel, [8] lru_write, [7:6] lru_way, [5:4] data_sel, [3:0] data_load
  logic [9:0] exp_q[$];

  logic [10:0] m_tag [4];
  logic [3:0]  m_valid, m_dirty;

  // ---------------- scoreboard monitor ----------------
  bit prev_resp = 0;
  always @(negedge clk) begin
    logic [9:0] e;
    if (reset) begin
      prev_resp = 0;
    end else begin
      checks++;
      if (pmem_read && pmem_write) begin
        errors++;
        $display("FAIL pmem_overlap: pmem_read=%b pmem_write=%b, required not both high", pmem_read, pmem_write);
      end
      if (l1_resp) begin
        checks++;
        if (prev_resp) begin
          errors++;
          $display("FAIL resp_pulse: l1_resp high two cycles in a row");
        end
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: l1_resp with empty expected queue");
        end else begin
          e = exp_q.pop_front();
          if (l1_rdata_sel !== e[9] || lru_write !== e[8] || data_load !== e[3:0] ||
              (e[8] && lru_way !== e[7:6]) ||
              (!e[9] && e[3:0] == 4'd0 && data_sel !== e[5:4])) begin
            errors++;
            $display("FAIL resp_fields: got rsel=%b lru_wr=%b lru_way=%0d dsel=%0d dload=%b, required rsel=%b lru_wr=%b lru_way=%0d dsel=%0d dload=%b",
                     l1_rdata_sel, lru_write, lru_way, data_sel, data_load,
                     e[9], e[8], e[7:6], e[5:4], e[3:0]);
          end
        end
      end
      prev_resp = l1_resp;
    end
  end

  // ---------------- model ----------------
  task automatic model_reset();
    m_valid = 4'd0;
    m_dirty = 4'd0;
    for (int i = 0; i < 4; i++) m_tag[i] = '0;
    exp_q.delete();
  endtask

  task automatic model_write(input logic [10:0] tag, input logic d,
                             output int way, output bit wb, output logic [10:0] old_tag);
    bit hit = 0;
    way = -1;
    for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == tag) begin hit = 1; way = i; end
    if (!hit) for (int i = 3; i >= 0; i--) if (!m_valid[i]) way = i;
    if (way < 0) way = int'(lru_replace);
    wb      = !hit && m_valid[way] && m_dirty[way];
    old_tag = m_tag[way];
    m_dirty[way] = hit ? (m_dirty[way] | d) : d;
    m_valid[way] = 1'b1;
    m_tag[way]   = tag;
    exp_q.push_back({1'b0, 1'b1, 2'(way), 2'(way), 4'(4'b0001 << way)});
  endtask

  task automatic model_read(input logic [10:0] tag, output bit hit);
    int way = 0;
    hit = 0;
    for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == tag) begin hit = 1; way = i; end
    if (hit) exp_q.push_back({1'b0, 1'b1, 2'(way), 2'(way), 4'd0});
    else     exp_q.push_back({1'b1, 1'b0, 2'd0, 2'd0, 4'd0});
  endtask

  // ---------------- drivers ----------------
  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1; l1_read = 0; l1_write = 0; pmem_resp = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // Drives one request, answers pmem after lat strobe cycles, returns once all responses are seen.
  // cyc counts negedges from request; a completion in the cycle after sampling gives cyc == 2.
  task automatic drive_op(input logic rd, input logic wr, input logic [10:0] tag, input logic d,
                          input int lat, output int cyc, output bit saw_rd, output bit saw_wr,
                          output logic [15:0] addr);
    int pc = 0, nresp = 0, need;
    bit want, got;
    need = (rd && wr) ? 2 : 1;
    @(posedge clk); #1;
    l1_read = rd; l1_write = wr; l1_tag = tag; l1_dirty = d;
    cyc = 0; saw_rd = 0; saw_wr = 0; addr = '0;
    while (nresp < need && cyc < 200) begin
      @(negedge clk);
      cyc++;
      want = 0;
      got  = l1_resp;
      if (pmem_read || pmem_write) begin
        saw_rd |= pmem_read;
        saw_wr |= pmem_write;
        addr = pmem_addr;
        pc++;
        want = (pc >= lat) && !pmem_resp;
      end
      if (got) nresp++;
      @(posedge clk); #1;
      pmem_resp = want;
      if (got) l1_write = 1'b0;
    end
    l1_read = 0; l1_write = 0; pmem_resp = 0;
    if (nresp < need) begin
      checks++; errors++;
      $display("FAIL op_timeout: saw %0d responses, required %0d", nresp, need);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({l1_resp, l1_rdata_sel, data_sel, data_load, pmem_read, pmem_write, lru_write, lru_way} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: resp=%b rsel=%b dsel=%0d dload=%b prd=%b pwr=%b lru_wr=%b lru_way=%0d, required all 0",
               l1_resp, l1_rdata_sel, data_sel, data_load, pmem_read, pmem_write, lru_write, lru_way);
    end
    checks++;
    if (pmem_addr !== 16'd0) begin errors++; $display("FAIL reset_addr: got %h required 0000", pmem_addr); end
    checks++;
    if (dbg_state !== 3'd0 || dbg_valid !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d valid=%b, required 0 and 0000", dbg_state, dbg_valid);
    end
  endtask

  task automatic test_read_miss();
    int cyc; bit srd, swr, hit; logic [15:0] a;
    model_read(11'h123, hit);
    drive_op(1, 0, 11'h123, 0, 2, cyc, srd, swr, a);
    checks++;
    if (!srd || swr || a !== 16'h2460) begin
      errors++;
      $display("FAIL read_miss_pmem: rd=%b wr=%b addr=%h, required rd=1 wr=0 addr=2460", srd, swr, a);
    end
    checks++;
    if (dbg_valid !== 4'b0000) begin errors++; $display("FAIL read_miss_valid: got %b required 0000", dbg_valid); end
  endtask

  task automatic test_fill();
    int cyc, way; bit srd, swr, wb; logic [15:0] a; logic [10:0] old;
    for (int i = 0; i < 4; i++) begin
      model_write(11'(i + 1), 0, way, wb, old);
      drive_op(0, 1, 11'(i + 1), 0, 1, cyc, srd, swr, a);
      checks++;
      if (cyc != 2 || srd || swr) begin
        errors++;
        $display("FAIL fill_%0d: cyc=%0d rd=%b wr=%b, required cyc=2 no pmem", i, cyc, srd, swr);
      end
      checks++;
      if (dbg_valid !== m_valid) begin
        errors++;
        $display("FAIL fill_valid_%0d: got %b required %b", i, dbg_valid, m_valid);
      end
    end
  endtask

  task automatic test_read_hit();
    int cyc; bit srd, swr, hit; logic [15:0] a;
    model_read(11'h002, hit);
    drive_op(1, 0, 11'h002, 0, 1, cyc, srd, swr, a);
    checks++;
    if (cyc != 2 || srd || swr) begin
      errors++;
      $display("FAIL read_hit_latency: cyc=%0d rd=%b wr=%b, required cyc=2 no pmem", cyc, srd, swr);
    end
  endtask

  task automatic test_evict();
    int cyc, way; bit srd, swr, wb, hit; logic [15:0] a; logic [10:0] old;
    // Make way 2 (tag 0x003) dirty via a write hit, then evict it.
    model_write(11'h003, 1, way, wb, old);
    drive_op(0, 1, 11'h003, 1, 1, cyc, srd, swr, a);
    lru_replace = 2'd2;
    model_write(11'h0AA, 0, way, wb, old);
    drive_op(0, 1, 11'h0AA, 0, 3, cyc, srd, swr, a);
    checks++;
    if (!swr || srd || a !== 16'h0060) begin
      errors++;
      $display("FAIL evict_wb: wr=%b rd=%b addr=%h, required wr=1 rd=0 addr=0060", swr, srd, a);
    end
    model_read(11'h0AA, hit);
    drive_op(1, 0, 11'h0AA, 0, 1, cyc, srd, swr, a);
    model_read(11'h003, hit);
    drive_op(1, 0, 11'h003, 0, 1, cyc, srd, swr, a);
    checks++;
    if (!srd || a !== 16'h0060) begin
      errors++;
      $display("FAIL evicted_miss: rd=%b addr=%h, required rd=1 addr=0060", srd, a);
    end
    // A clean rewrite of a dirty line must keep it dirty.
    model_write(11'h001, 1, way, wb, old);
    drive_op(0, 1, 11'h001, 1, 1, cyc, srd, swr, a);
    model_write(11'h001, 0, way, wb, old);
    drive_op(0, 1, 11'h001, 0, 1, cyc, srd, swr, a);
    lru_replace = 2'd0;
    model_write(11'h0BB, 0, way, wb, old);
    drive_op(0, 1, 11'h0BB, 0, 2, cyc, srd, swr, a);
    checks++;
    if (!swr || a !== 16'h0020) begin
      errors++;
      $display("FAIL dirty_merge_wb: wr=%b addr=%h, required wr=1 addr=0020", swr, a);
    end
    lru_replace = 2'd1;
    model_write(11'h0CC, 0, way, wb, old);
    drive_op(0, 1, 11'h0CC, 0, 1, cyc, srd, swr, a);
    checks++;
    if (swr || srd || cyc != 2) begin
      errors++;
      $display("FAIL clean_evict: wr=%b rd=%b cyc=%0d, required no pmem cyc=2", swr, srd, cyc);
    end
  endtask

  task automatic test_simultaneous();
    int cyc, way; bit srd, swr, wb, hit; logic [15:0] a; logic [10:0] old;
    model_write(11'h0AA, 1, way, wb, old);
    model_read(11'h0AA, hit);
    drive_op(1, 1, 11'h0AA, 1, 1, cyc, srd, swr, a);
    checks++;
    if (exp_q.size() != 0 || srd || swr) begin
      errors++;
      $display("FAIL simultaneous: pending=%0d rd=%b wr=%b, required 0 pending no pmem", exp_q.size(), srd, swr);
    end
  endtask

  task automatic test_reset_in_wb();
    int cyc, way; bit srd, swr, wb, hit; logic [15:0] a; logic [10:0] old;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      model_write(11'h010 + 11'(i), 1, way, wb, old);
      drive_op(0, 1, 11'h010 + 11'(i), 1, 1, cyc, srd, swr, a);
    end
    lru_replace = 2'd3;
    @(posedge clk); #1;
    l1_write = 1; l1_tag = 11'h055; l1_dirty = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (pmem_write !== 1'b1 || pmem_addr !== 16'h0260) begin
      errors++;
      $display("FAIL wb_before_reset: wr=%b addr=%h, required wr=1 addr=0260", pmem_write, pmem_addr);
    end
    @(posedge clk); #1;
    reset = 1; l1_write = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (pmem_write !== 1'b0 || dbg_valid !== 4'd0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_in_wb: wr=%b valid=%b state=%0d, required 0 0000 0", pmem_write, dbg_valid, dbg_state);
    end
    @(posedge clk); #1 reset = 0;
    model_reset();
    model_read(11'h013, hit);
    drive_op(1, 0, 11'h013, 0, 1, cyc, srd, swr, a);
    checks++;
    if (!srd || a !== 16'h0260) begin
      errors++;
      $display("FAIL post_reset_miss: rd=%b addr=%h, required rd=1 addr=0260", srd, a);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, way, lat; bit srd, swr, wb, hit; logic [15:0] a; logic [10:0] old, tag; logic d;
    for (int n = 0; n < 30; n++) begin
      lat = $urandom_range(1, 4);
      tag = ($urandom_range(0, 1) == 1) ? m_tag[$urandom_range(0, 3)] : 11'h100 + 11'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        d = 1'($urandom_range(0, 1));
        lru_replace = 2'($urandom_range(0, 3));
        model_write(tag, d, way, wb, old);
        drive_op(0, 1, tag, d, lat, cyc, srd, swr, a);
        checks++;
        if (swr !== wb || srd || (wb && a !== {old, 5'b0})) begin
          errors++;
          $display("FAIL b2b_write_%0d: wr=%b rd=%b addr=%h, required wr=%b rd=0 addr=%h",
                   n, swr, srd, a, wb, {old, 5'b0});
        end
      end else begin
        model_read(tag, hit);
        drive_op(1, 0, tag, 0, lat, cyc, srd, swr, a);
        checks++;
        if (swr || srd !== !hit || (!hit && a !== {tag, 5'b0})) begin
          errors++;
          $display("FAIL b2b_read_%0d: rd=%b wr=%b addr=%h, required rd=%b wr=0 addr=%h",
                   n, srd, swr, a, !hit, {tag, 5'b0});
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_read_miss();
    test_fill();
    test_read_hit();
    test_evict();
    test_simultaneous();
    test_reset_in_wb();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
